coin_detect_1058: RTL



---
 rtl/coin_detect_1058.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/coin_detect_1058.sv
// coin_detect_1058: front end of the coffee vending controller.
// Synchronises and debounces the three coin sensors and the stop key, and
// turns each validated event into a single-cycle registered pulse.
// A coin arriving while lock_slit is high is answered with coin_reject.
module coin_detect_1058 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk4m,
    input  logic rst,
    input  logic sense_c20,
    input  logic sense_c50,
    input  logic sense_e01,
    input  logic stop_key,
    input  logic lock_slit,
    output logic cent20,
    output logic cent50,
    output logic euro01,
    output logic stop_buy,
    output logic coin_reject,
    output logic busy
);

    // Coin FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUALIFY = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Stop-key debouncer encoding
    localparam logic [0:0] SP_WAIT_PRESS   = 1'b0;
    localparam logic [0:0] SP_WAIT_RELEASE = 1'b1;

    // Counter value reached on the last of DEBOUNCE_CYCLES stable samples
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Saturation ceiling; counters hold here instead of wrapping
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Synchroniser: bit order {stop_key, sense_e01, sense_c50, sense_c20}
    // ------------------------------------------------------------------
    logic [3:0] raw_in;
    logic [3:0] sync_meta_d, sync_meta_q;
    logic [3:0] sync_d, sync_q;

    assign raw_in = {stop_key, sense_e01, sense_c50, sense_c20};

    // Two-stage shift; the first stage may go metastable, the second is used
    always_comb begin
        sync_meta_d = raw_in;
        sync_d      = sync_meta_q;
    end

    logic [2:0] coin_pat;
    logic       key_sync;

    assign coin_pat = sync_q[2:0];
    assign key_sync = sync_q[3];

    // ------------------------------------------------------------------
    // Coin FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_d, state_q;
    logic [2:0]       pat_d, pat_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             pat_multi;

    logic cent20_d, cent20_q;
    logic cent50_d, cent50_q;
    logic euro01_d, euro01_q;
    logic reject_d, reject_q;
    logic busy_d, busy_q;

    // Saturating increment of the coin counter
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_inc = cnt_q;
        end else begin
            cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    // More than one sensor active in the captured pattern means we cannot
    // tell which coin it was, so it is rejected rather than guessed
    assign pat_multi = (pat_q[0] & pat_q[1]) | (pat_q[0] & pat_q[2]) |
                       (pat_q[1] & pat_q[2]);

    // Coin state machine: capture, qualify for DEBOUNCE_CYCLES samples,
    // emit one pulse, then wait for a clean release before rearming
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        cent20_d = 1'b0;
        cent50_d = 1'b0;
        euro01_d = 1'b0;
        reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_pat != 3'b000) begin
                    // The capture cycle itself is the first stable sample
                    pat_d   = coin_pat;
                    cnt_d   = '0;
                    state_d = ST_QUALIFY;
                end
            end

            ST_QUALIFY: begin
                if (coin_pat == pat_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d = ST_EMIT;
                    end
                end else begin
                    // Glitch or a second sensor joining: drop this attempt
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_EMIT: begin
                // lock_slit only matters at this single decision point
                if (lock_slit || pat_multi) begin
                    reject_d = 1'b1;
                end else begin
                    cent20_d = pat_q[0];
                    cent50_d = pat_q[1];
                    euro01_d = pat_q[2];
                end
                cnt_d   = '0;
                state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (coin_pat != 3'b000) begin
                    // Coin still on the sensor: restart the quiet-time count
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks state_q exactly
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Stop-key debouncer
    // ------------------------------------------------------------------
    logic [0:0]       sp_state_d, sp_state_q;
    logic [CNT_W-1:0] sp_cnt_d, sp_cnt_q;
    logic [CNT_W-1:0] sp_cnt_inc;
    logic             sp_hit_d, sp_hit_q;
    logic             stop_buy_d, stop_buy_q;

    // Saturating increment of the stop counter
    always_comb begin
        if (sp_cnt_q == CNT_MAX) begin
            sp_cnt_inc = sp_cnt_q;
        end else begin
            sp_cnt_inc = sp_cnt_q + CNT_W'(1);
        end
    end

    // Stop-key state machine: count consecutive high samples to accept a
    // press, then consecutive low samples before another press can count
    always_comb begin
        sp_state_d = sp_state_q;
        sp_cnt_d   = sp_cnt_q;
        sp_hit_d   = 1'b0;

        case (sp_state_q)
            SP_WAIT_PRESS: begin
                if (key_sync) begin
                    if (sp_cnt_q == CNT_LAST) begin
                        sp_hit_d   = 1'b1;
                        sp_cnt_d   = '0;
                        sp_state_d = SP_WAIT_RELEASE;
                    end else begin
                        sp_cnt_d = sp_cnt_inc;
                    end
                end else begin
                    sp_cnt_d = '0;
                end
            end

            default: begin
                if (!key_sync) begin
                    if (sp_cnt_q == CNT_LAST) begin
                        sp_cnt_d   = '0;
                        sp_state_d = SP_WAIT_PRESS;
                    end else begin
                        sp_cnt_d = sp_cnt_inc;
                    end
                end else begin
                    sp_cnt_d = '0;
                end
            end
        endcase

        // One extra register stage: the coin path spends a cycle in EMIT,
        // so this keeps a key press and a coin that rise together aligned
        stop_buy_d = sp_hit_q;
    end

    // ------------------------------------------------------------------
    // All state and output registers, asynchronously cleared
    // ------------------------------------------------------------------
    always_ff @(posedge clk4m or posedge rst) begin
        if (rst) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            cnt_q       <= '0;
            cent20_q    <= 1'b0;
            cent50_q    <= 1'b0;
            euro01_q    <= 1'b0;
            reject_q    <= 1'b0;
            busy_q      <= 1'b0;
            sp_state_q  <= SP_WAIT_PRESS;
            sp_cnt_q    <= '0;
            sp_hit_q    <= 1'b0;
            stop_buy_q  <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            state_q     <= state_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            cent20_q    <= cent20_d;
            cent50_q    <= cent50_d;
            euro01_q    <= euro01_d;
            reject_q    <= reject_d;
            busy_q      <= busy_d;
            sp_state_q  <= sp_state_d;
            sp_cnt_q    <= sp_cnt_d;
            sp_hit_q    <= sp_hit_d;
            stop_buy_q  <= stop_buy_d;
        end
    end

    assign cent20      = cent20_q;
    assign cent50      = cent50_q;
    assign euro01      = euro01_q;
    assign coin_reject = reject_q;
    assign stop_buy    = stop_buy_q;
    assign busy        = busy_q;

endmodule
